pwm_fan_driver: RTL and testbench
=================================

PWM_FAN_DRIVER -- requirements
Module: pwm_fan_driver

Interface
REQ-001 SHALL have parameter ADC_BITWIDTH, default 8, giving the duty/counter width (N).
REQ-002 SHALL have parameter MIN_DUTY, default 16, giving the smallest nonzero duty applied in RUN.
REQ-003 SHALL have parameter KICK_PERIODS, default 4, giving the number of full-duty spin-up periods (range 1..15).
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port ena_i, input, 1 bit: block enable, synchronous.
REQ-007 SHALL have port prescale_i, input, 8 bits: PWM tick divider; a tick occurs every prescale_i+1 cycles.
REQ-008 SHALL have port pid_val_i, input, signed N+1 bits: controller output, two's complement.
REQ-009 SHALL have port pwm_o, output, 1 bit: registered fan PWM.
REQ-010 SHALL have port clk_en_PID_o, output, 1 bit: one-cycle controller update strobe.
REQ-011 SHALL have port duty_o, output, N bits: active duty.
REQ-012 SHALL have port state_o, output, 2 bits: FSM state, encoded OFF=0, KICK=1, RUN=2.

Function
REQ-013 SHALL run prescaler psc counting 0..prescale_i; tick when psc==prescale_i (psc then wraps to 0); prescale_i=0 gives a tick every cycle.
REQ-014 SHALL advance period counter cnt by 1 on each tick, range 0..2^N-2; period = 2^N-1 ticks.
REQ-015 SHALL define period end as tick AND cnt==2^N-2; at period end, cnt wraps to 0.
REQ-016 SHALL update pwm_o every cycle to (cnt < duty_o) of the current register values, i.e. one cycle behind the counter.
REQ-017 SHALL give: duty 0 -> pwm_o constantly 0; duty 2^N-1 -> pwm_o constantly 1.
REQ-018 SHALL compute target at period end only: pid_val_i<0 -> 0; 0 -> 0; 1..MIN_DUTY-1 -> MIN_DUTY; otherwise pid_val_i[N-1:0].
REQ-019 SHALL make FSM transitions only at period end:
  - OFF->KICK if target!=0, else stay OFF.
  - KICK->OFF if target==0.
  - KICK->RUN when the kick counter reaches KICK_PERIODS.
  - RUN->OFF if target==0.
REQ-020 SHALL reset the kick counter on entry to KICK and increment it on each KICK period end.
REQ-021 SHALL set duty_o per state: OFF -> 0; KICK -> 2^N-1; RUN -> target latched at each period end. The register updates in the same edge as the state change, so the new duty governs the following period.
REQ-022 SHALL pulse clk_en_PID_o high for exactly one cycle, in the cycle after every period end, so pid_val_i settles before the next sample.
REQ-023 SHALL ignore pid_val_i changes between period ends.
REQ-024 SHALL use a prescale_i change from the next psc wrap onward; it never truncates the current tick.
REQ-025 SHALL, while ena_i=0: clear psc and cnt, set state to OFF and duty_o to 0, and suppress clk_en_PID_o; pwm_o goes 0 on the next edge.
REQ-026 SHALL restart from cnt=0 in OFF when ena_i rises, with the first period end 2^N-1 ticks later.
REQ-027 SHALL let ena_i dropping mid-KICK or mid-RUN abort immediately; no period completion.

Reset
REQ-028 SHALL, while rstn_i=0, asynchronously clear psc, cnt, the kick counter, duty_o, pwm_o and clk_en_PID_o to 0 and set state_o to OFF.
REQ-029 SHALL resume the first tick counting from psc=0 after rstn_i deasserts, on the first clock edge with ena_i=1.

Verification
REQ-030 SHALL cover: prescale_i=0, ena_i=1, pid_val_i=+100 -> first period end at cycle 254; KICK with pwm_o high for 4x255 cycles; then RUN with duty_o=100 and pwm_o high 100 of every 255 cycles.
REQ-031 SHALL cover: in RUN, pid_val_i=-37 -> at next period end state OFF, duty_o=0, pwm_o=0 from the following cycle.
REQ-032 SHALL cover: pid_val_i=+5 after spin-up -> duty_o=16; pid_val_i=+255 -> pwm_o constantly 1.
REQ-033 SHALL cover: prescale_i=3 -> clk_en_PID_o single-cycle pulses exactly 1020 cycles apart; the pulse is the cycle after cnt wraps.
REQ-034 SHALL cover: pid_val_i falls to 0 during KICK period 2 -> KICK->OFF at that period end, with no RUN.
REQ-035 SHALL cover: rstn_i low asynchronously mid-RUN -> all outputs 0 and state_o=0 before the next clock edge; ena_i low mid-KICK -> state_o=0 at the next edge.

Source files
------------

// File: rtl/pwm_fan_driver.sv
// pwm_fan_driver: fan PWM generator with spin-up kick, minimum-duty clamp and controller update strobe
// Ports: clk_i clock; rstn_i async active-low reset; ena_i synchronous enable;
//        prescale_i tick divider (one tick every prescale_i+1 cycles);
//        pid_val_i signed controller output, sampled only at period end;
//        pwm_o registered PWM; clk_en_PID_o one-cycle strobe after each period end;
//        duty_o active duty; state_o FSM state (OFF=0, KICK=1, RUN=2).
module pwm_fan_driver #(
    parameter int ADC_BITWIDTH = 8,
    parameter int MIN_DUTY     = 16,
    parameter int KICK_PERIODS = 4
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           ena_i,
    input  logic [7:0]                     prescale_i,
    input  logic signed [ADC_BITWIDTH:0]   pid_val_i,
    output logic                           pwm_o,
    output logic                           clk_en_PID_o,
    output logic [ADC_BITWIDTH-1:0]        duty_o,
    output logic [1:0]                     state_o
);
    localparam int N = ADC_BITWIDTH;
    localparam logic [N-1:0] CNT_LAST  = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] DUTY_MIN  = N'(MIN_DUTY);
    localparam logic [3:0]   KICK_LAST = 4'(KICK_PERIODS - 1);

    typedef enum logic [1:0] {OFF = 2'd0, KICK = 2'd1, RUN = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [7:0]   psc_q, lim_q, lim;
    logic [N-1:0] cnt_q, duty_d, target;
    logic [3:0]   kick_q, kick_d;
    logic         tick, period_end;

    // The divider limit is captured at the start of each tick interval, so a
    // prescale change takes effect only after the current tick completes.
    assign lim        = (psc_q == 8'd0) ? prescale_i : lim_q;
    assign tick       = ena_i && (psc_q == lim);
    assign period_end = tick && (cnt_q == CNT_LAST);
    // Non-positive requests stop the fan; small positive ones are lifted to the
    // lowest duty that still keeps it turning.
    assign target     = (pid_val_i[N] || pid_val_i == '0) ? '0 :
                        (pid_val_i[N-1:0] < DUTY_MIN) ? DUTY_MIN : pid_val_i[N-1:0];
    assign state_o    = state_q;

    always_comb begin
        state_d = state_q;
        kick_d  = kick_q;
        duty_d  = duty_o;
        if (!ena_i) begin
            state_d = OFF;
            kick_d  = '0;
            duty_d  = '0;
        end else if (period_end) begin
            case (state_q)
                OFF: begin
                    state_d = (target != '0) ? KICK : OFF;
                    kick_d  = '0;
                end
                KICK: begin
                    kick_d  = kick_q + 4'd1;
                    state_d = (target == '0) ? OFF : (kick_q == KICK_LAST) ? RUN : KICK;
                end
                RUN:     state_d = (target == '0) ? OFF : RUN;
                default: state_d = OFF;
            endcase
            duty_d = (state_d == OFF) ? '0 : (state_d == KICK) ? '1 : target;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= OFF;
            kick_q  <= '0;
            duty_o  <= '0;
        end else begin
            state_q <= state_d;
            kick_q  <= kick_d;
            duty_o  <= duty_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            psc_q        <= '0;
            lim_q        <= '0;
            cnt_q        <= '0;
            pwm_o        <= 1'b0;
            clk_en_PID_o <= 1'b0;
        end else begin
            lim_q        <= lim;
            psc_q        <= (!ena_i || tick) ? '0 : psc_q + 8'd1;
            cnt_q        <= !ena_i ? '0 : !tick ? cnt_q : period_end ? '0 : cnt_q + 1'b1;
            pwm_o        <= ena_i && (cnt_q < duty_o);
            clk_en_PID_o <= period_end;
        end
    end
endmodule

// File: tb/tb_pwm_fan_driver.sv
// tb_pwm_fan_driver: scoreboard bench for pwm_fan_driver against a period-level reference model
module tb_pwm_fan_driver;
    localparam int N   = 8;
    localparam int W   = N + 1;
    localparam int MIN = 16;
    localparam int KP  = 4;

    logic                clk_i = 1'b0;
    logic                rstn_i = 1'b0;
    logic                ena_i = 1'b0;
    logic [7:0]          prescale_i = 8'd0;
    logic signed [N:0]   pid_val_i = '0;
    logic                pwm_o;
    logic                clk_en_PID_o;
    logic [N-1:0]        duty_o;
    logic [1:0]          state_o;

    always #5 clk_i = ~clk_i;

    pwm_fan_driver #(.ADC_BITWIDTH(N), .MIN_DUTY(MIN), .KICK_PERIODS(KP)) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .ena_i(ena_i),
        .prescale_i(prescale_i),
        .pid_val_i(pid_val_i),
        .pwm_o(pwm_o),
        .clk_en_PID_o(clk_en_PID_o),
        .duty_o(duty_o),
        .state_o(state_o)
    );

    typedef struct {
        int state;
        int duty;
        int hi;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int m_state, m_kick, m_duty, cur_p;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int target_of(int pid);
        return (pid <= 0) ? 0 : (pid < MIN) ? MIN : pid;
    endfunction

    function automatic int rand_pid();
        case ($urandom_range(0, 5))
            0:       return -int'($urandom_range(1, 256));
            1:       return 0;
            2:       return int'($urandom_range(1, MIN - 1));
            default: return int'($urandom_range(MIN, 255));
        endcase
    endfunction

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start(int presc);
        prescale_i = 8'(presc);
        cur_p      = presc;
        m_state    = 0;
        m_kick     = 0;
        m_duty     = 0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        ena_i  = 1'b1;
    endtask

    // One PWM period: predict the outcome of the coming period end, scramble
    // pid_val_i for the first half, settle it to pid, then wait for the strobe.
    task automatic period(int pid);
        exp_t e;
        int t;
        int per = 255 * (cur_p + 1);
        bit got = 1'b0;
        t    = target_of(pid);
        e.hi = m_duty * (cur_p + 1);
        case (m_state)
            0: if (t != 0) begin
                m_state = 1;
                m_kick  = 0;
            end
            1: if (t == 0) m_state = 0;
               else begin
                   m_kick++;
                   if (m_kick == KP) m_state = 2;
               end
            default: if (t == 0) m_state = 0;
        endcase
        m_duty  = (m_state == 0) ? 0 : (m_state == 1) ? 255 : t;
        e.state = m_state;
        e.duty  = m_duty;
        q.push_back(e);
        pid_val_i = W'($urandom);
        cyc(per / 2);
        pid_val_i = W'(pid);
        for (int i = 0; i < per + 8 && !got; i++) begin
            cyc(1);
            got = clk_en_PID_o;
        end
        check("pulse_seen", int'(got), 1);
        if (!got) q.delete();
    endtask

    initial begin
        int gap = 0;
        int hi = 0;
        bit prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!(rstn_i && ena_i)) begin
                gap  = 0;
                hi   = 0;
                prev = 1'b0;
            end else begin
                hi += int'(pwm_o);
                if (clk_en_PID_o) begin
                    check("single_pulse", int'(prev), 0);
                    check("pending_expect", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("state", int'(state_o), e.state);
                        check("duty", int'(duty_o), e.duty);
                        check("hi_cycles", hi, e.hi);
                        check("gap", gap, 255 * (cur_p + 1));
                    end
                    gap = 1;
                    hi  = 0;
                end else begin
                    gap++;
                end
                prev = clk_en_PID_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_strobe", int'(clk_en_PID_o), 0);
        check("rst_duty", int'(duty_o), 0);
        check("rst_state", int'(state_o), 0);

        start(0);
        repeat (6) period(100);
        period(5);
        period(255);
        period(255);
        period(-37);
        period(0);
        repeat (6) period(50);
        cyc(60);
        check("pre_reset_state", int'(state_o), 2);
        @(posedge clk_i);
        #3;
        rstn_i = 1'b0;
        ena_i  = 1'b0;
        #1;
        check("async_pwm", int'(pwm_o), 0);
        check("async_strobe", int'(clk_en_PID_o), 0);
        check("async_duty", int'(duty_o), 0);
        check("async_state", int'(state_o), 0);
        q.delete();
        cyc(2);

        start(3);
        period(80);
        period(80);
        period(0);
        period(0);
        repeat (10) period(rand_pid());
        cyc(1);
        ena_i = 1'b0;
        cyc(2);
        check("seg2_drained", q.size(), 0);

        start(1);
        period(30);
        cyc(20);
        check("pre_ena_state", int'(state_o), 1);
        ena_i = 1'b0;
        cyc(1);
        check("ena_state", int'(state_o), 0);
        check("ena_duty", int'(duty_o), 0);
        check("ena_pwm", int'(pwm_o), 0);
        check("ena_strobe", int'(clk_en_PID_o), 0);
        cyc(2);

        start(int'($urandom_range(0, 2)));
        repeat (12) period(rand_pid());
        cyc(3);
        check("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
